// File: rtl/sf_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Provides the FSM state encoding, the rotate-priority pick helper and
// the pointer-advance helper. Sized for up to MAX_REQ requesters.
package sf_arb_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned MAX_REQ    = 8;
    localparam int unsigned IDX_W      = 3;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 1'b0;
    localparam arb_state_t ST_BURST = 1'b1;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Advance a requester index by one, wrapping at n.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx,
                                                  input int unsigned      n);
        return ((32'(idx) + 32'd1) >= n) ? '0 : idx + IDX_W'(1);
    endfunction

    // First requester at or after ptr (modulo n) with its request bit set.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int unsigned        n);
        pick_t       p;
        logic [31:0] k;
        p = '0;
        for (int unsigned off = 0; off < MAX_REQ; off++) begin
            k = (32'(ptr) + off) % n;
            if ((off < n) && !p.valid && req[k[IDX_W-1:0]]) begin
                p.valid = 1'b1;
                p.idx   = k[IDX_W-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/sf_rr_picker.sv
// Combinational rotate-priority encoder.
// Ports:
//   req     in   per-requester request vector
//   ptr     in   index holding highest priority
//   valid_c out  some requester is asserting
//   idx_c   out  winning requester index
module sf_rr_picker
    import sf_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid_c,
    output logic [IDX_W-1:0]   idx_c
);

    pick_t pick;

    always_comb begin
        pick    = rr_pick(MAX_REQ'(req), ptr, NUM_REQ);
        valid_c = pick.valid;
        idx_c   = pick.idx;
    end

endmodule

// File: rtl/sf_write_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among
// NUM_REQ producers, with bounded burst ownership and an internal
// occupancy (credit) counter so a registered w_en never overflows.
// Ports:
//   clk, rst      clock, async active-high reset
//   req, data     per-requester request level and data slices
//   ack           combinational one-hot beat accept
//   grant         registered one-hot owner, 0 when idle
//   w_en, data_in registered FIFO write side
//   full, empty   FIFO flags; r_en consumer read enable (observed)
//   level         tracked occupancy; overflow_err sticky w_en&full
module sf_write_arbiter
    import sf_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned DATA_W    = DATA_W_DEF,
    parameter  int unsigned DEPTH     = 8,
    parameter  int unsigned MAX_BURST = 4,
    localparam int unsigned LVL_W     = $clog2(DEPTH + 1),
    localparam int unsigned BEAT_W    = $clog2(MAX_BURST + 1)
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      w_en,
    output logic [DATA_W-1:0]         data_in,
    input  logic                      full,
    input  logic                      empty,
    input  logic                      r_en,
    output logic [LVL_W-1:0]          level,
    output logic                      overflow_err
);

    localparam int unsigned CRD_W = LVL_W + 1;

    arb_state_t          state, state_n;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0]    owner, owner_n;
    logic [IDX_W-1:0]    pick_ptr, pick_idx, take_idx;
    logic [BEAT_W-1:0]   beat_cnt, beat_n;
    logic [NUM_REQ-1:0]  grant_n;
    logic [MAX_REQ-1:0]  req_ext;
    logic [DATA_W-1:0]   data_arr [MAX_REQ];
    logic                pick_valid, credit_ok, take, rel, arb, wr, rd;

    // Unpack data slices; unused upper slots read as zero.
    for (genvar i = 0; i < MAX_REQ; i++) begin : g_slice
        if (i < NUM_REQ) begin : g_used
            assign data_arr[i] = data[i*DATA_W +: DATA_W];
        end else begin : g_pad
            assign data_arr[i] = '0;
        end
    end

    assign req_ext = MAX_REQ'(req);

    // The pending w_en is counted as already written; same-cycle reads are not credited.
    assign credit_ok = (CRD_W'(level) + CRD_W'(w_en)) < CRD_W'(DEPTH);

    // On release the pointer moves past the owner before re-arbitrating.
    assign pick_ptr = (state == ST_BURST) ? next_ptr(owner, NUM_REQ) : rr_ptr;

    assign wr = w_en & ~full;
    assign rd = r_en & ~empty;

    sf_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req     (req),
        .ptr     (pick_ptr),
        .valid_c (pick_valid),
        .idx_c   (pick_idx)
    );

    // Next-state: burst continue / stall / release, then same-cycle re-arbitration.
    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        owner_n  = owner;
        beat_n   = beat_cnt;
        grant_n  = grant;
        take     = 1'b0;
        take_idx = owner;
        rel      = 1'b0;
        arb      = 1'b0;

        case (state)
            ST_BURST: begin
                if (!req_ext[owner]) begin
                    rel = 1'b1;
                end else if (credit_ok) begin
                    if (beat_cnt < BEAT_W'(MAX_BURST)) begin
                        take   = 1'b1;
                        beat_n = beat_cnt + BEAT_W'(1);
                    end else begin
                        rel = 1'b1;
                    end
                end
                // req held without credit: stall and keep ownership
            end
            default: begin
                grant_n = '0;
                arb     = 1'b1;
            end
        endcase

        if (rel) begin
            rr_ptr_n = pick_ptr;
            grant_n  = '0;
            state_n  = ST_IDLE;
            arb      = 1'b1;
        end

        if (arb && pick_valid && credit_ok) begin
            take     = 1'b1;
            take_idx = pick_idx;
            owner_n  = pick_idx;
            grant_n  = NUM_REQ'(1) << pick_idx;
            beat_n   = BEAT_W'(1);
            if (MAX_BURST > 1) begin
                state_n = ST_BURST;
            end else begin
                state_n  = ST_IDLE;
                rr_ptr_n = next_ptr(pick_idx, NUM_REQ);
            end
        end
    end

    assign ack = (take && !rst) ? (NUM_REQ'(1) << take_idx) : '0;

    // State, write port and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            beat_cnt     <= '0;
            grant        <= '0;
            w_en         <= 1'b0;
            data_in      <= '0;
            level        <= '0;
            overflow_err <= 1'b0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            owner    <= owner_n;
            beat_cnt <= beat_n;
            grant    <= grant_n;
            w_en     <= take;
            if (take) begin
                data_in <= data_arr[take_idx];
            end
            if (wr && !rd) begin
                level <= level + LVL_W'(1);
            end else if (rd && !wr) begin
                level <= level - LVL_W'(1);
            end
            if (w_en && full) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sf_write_arbiter.sv
// Self-checking bench for sf_write_arbiter: a table of per-cycle vectors
// for round-robin rotation and early release, plus hand-written sequences
// for reset mid-burst, credit stall, steady read/write and overflow flag.
module tb_sf_write_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned DP = 8;
    localparam int unsigned MB = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    grant;
    logic             w_en;
    logic [DW-1:0]    data_in;
    logic             full;
    logic             empty;
    logic             r_en;
    logic [3:0]       level;
    logic             overflow_err;

    logic [3:0]       fcnt;
    logic             force_full;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sf_write_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .DEPTH     (DP),
        .MAX_BURST (MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .data         (data),
        .ack          (ack),
        .grant        (grant),
        .w_en         (w_en),
        .data_in      (data_in),
        .full         (full),
        .empty        (empty),
        .r_en         (r_en),
        .level        (level),
        .overflow_err (overflow_err)
    );

    // Behavioural FIFO occupancy driving the flags.
    assign full  = (fcnt == 4'd8) || force_full;
    assign empty = (fcnt == 4'd0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= '0;
        end else if ((w_en && !full) && !(r_en && !empty)) begin
            fcnt <= fcnt + 4'd1;
        end else if (!(w_en && !full) && (r_en && !empty)) begin
            fcnt <= fcnt - 4'd1;
        end
    end

    typedef struct packed {
        logic [3:0] req;
        logic       r_en;
        logic [3:0] ack;
        logic [3:0] grant;
        logic       w_en;
        logic [3:0] level;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req        = '0;
        r_en       = 1'b0;
        force_full = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [3:0] oh2idx(input logic [3:0] oh);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = 4'(i);
        end
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // req, r_en, exp ack (this cycle), exp grant / w_en / level (after edge)
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 4'd0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 4'd1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 4'd1};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 4'd1};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 4'd1};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 4'd1};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 4'd1};
        vecs[7]  = '{4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 4'd1};
        vecs[8]  = '{4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1, 4'd1};
        vecs[9]  = '{4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1, 4'd1};
        vecs[10] = '{4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1, 4'd1};
        vecs[11] = '{4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1, 4'd1};
        vecs[12] = '{4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 4'd1};
        vecs[13] = '{4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 4'd1};
        vecs[14] = '{4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 4'd1};
        vecs[15] = '{4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 4'd1};
        vecs[16] = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 4'd1};
        vecs[17] = '{4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1, 4'd1};
        vecs[18] = '{4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1, 4'd1};
        vecs[19] = '{4'b1001, 1'b1, 4'b1000, 4'b1000, 1'b1, 4'd1};
        vecs[20] = '{4'b1001, 1'b1, 4'b1000, 4'b1000, 1'b1, 4'd1};
        vecs[21] = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 4'd1};
        vecs[22] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd1};
        vecs[23] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0};

        // Reset state, with requests asserted to confirm ack is held off
        rst        = 1'b1;
        req        = 4'b1111;
        r_en       = 1'b0;
        force_full = 1'b0;
        data       = 32'h44332211;
        tick();
        tick();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_wen", 32'(w_en), 32'h0);
        chk("rst_data_in", 32'(data_in), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_ovf", 32'(overflow_err), 32'h0);

        // Reset in the middle of a burst
        rst = 1'b0;
        req = 4'b0010;
        @(negedge clk);
        chk("mid_ack0", 32'(ack), 32'h2);
        tick();
        @(negedge clk);
        chk("mid_ack1", 32'(ack), 32'h2);
        tick();
        chk("mid_grant", 32'(grant), 32'h2);
        chk("mid_level", 32'(level), 32'd1);
        chk("mid_data_in", 32'(data_in), 32'h22);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'h0);
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_wen", 32'(w_en), 32'h0);
        chk("mid_rst_data_in", 32'(data_in), 32'h0);
        chk("mid_rst_level", 32'(level), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b0011;
        @(negedge clk);
        chk("post_rst_first_ack", 32'(ack), 32'h1);
        tick();
        chk("post_rst_data_in", 32'(data_in), 32'h11);
        chk("post_rst_grant", 32'(grant), 32'h1);

        // Round-robin rotation and early release, draining every cycle
        do_reset();
        for (int i = 0; i < 24; i++) begin
            req  = vecs[i].req;
            r_en = vecs[i].r_en;
            for (int j = 0; j < 4; j++) begin
                data[j*8 +: 8] = {4'(j), 4'(i)};
            end
            @(negedge clk);
            chk($sformatf("row%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
            tick();
            chk($sformatf("row%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
            chk($sformatf("row%0d_wen", i), 32'(w_en), 32'(vecs[i].w_en));
            chk($sformatf("row%0d_level", i), 32'(level), 32'(vecs[i].level));
            if (vecs[i].w_en) begin
                chk($sformatf("row%0d_data_in", i), 32'(data_in),
                    32'({oh2idx(vecs[i].ack), 4'(i)}));
            end
        end

        // Credit stall: no reads, exactly DEPTH beats then hold ownership
        do_reset();
        data = 32'h3C2B1A09;
        req  = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("crd_ack%0d", k), 32'(ack), 32'h8);
            tick();
        end
        chk("crd_last_data_in", 32'(data_in), 32'h3C);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("crd_stall_ack%0d", k), 32'(ack), 32'h0);
            tick();
        end
        chk("crd_grant", 32'(grant), 32'h8);
        chk("crd_level", 32'(level), 32'd8);
        chk("crd_full", 32'(full), 32'h1);
        chk("crd_wen", 32'(w_en), 32'h0);
        chk("crd_ovf", 32'(overflow_err), 32'h0);
        r_en = 1'b1;
        @(negedge clk);
        chk("crd_rd_ack", 32'(ack), 32'h0);
        tick();
        r_en = 1'b0;
        chk("crd_rd_level", 32'(level), 32'd7);
        @(negedge clk);
        chk("crd_resume_ack", 32'(ack), 32'h8);
        tick();
        chk("crd_resume_wen", 32'(w_en), 32'h1);
        chk("crd_resume_grant", 32'(grant), 32'h8);
        @(negedge clk);
        chk("crd_refull_ack", 32'(ack), 32'h0);
        tick();
        chk("crd_refull_level", 32'(level), 32'd8);

        // Steady read and write at level 5
        do_reset();
        req = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rw_fill_ack%0d", k), 32'(ack), 32'h4);
            tick();
        end
        r_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("rw_ack%0d", k), 32'(ack), 32'h4);
            tick();
            chk($sformatf("rw_level%0d", k), 32'(level), 32'd5);
        end
        chk("rw_ovf_clear", 32'(overflow_err), 32'h0);

        // Sticky overflow flag when full rises under a pending write
        force_full = 1'b1;
        tick();
        force_full = 1'b0;
        chk("ovf_set", 32'(overflow_err), 32'h1);
        tick();
        tick();
        chk("ovf_sticky", 32'(overflow_err), 32'h1);
        do_reset();
        chk("ovf_reset", 32'(overflow_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
